// File: rtl/uart_echo_system.sv
// UART 8N1 echo: every byte received on rx_i is retransmitted unchanged on tx_o
// through a one-entry, newest-wins holding register.
module uart_echo_system #(
  parameter int clk_per_bit_p = 10416
) (
  input  logic sys_clk_i,
  input  logic reset_n_i,
  input  logic rx_i,
  output logic tx_o
);

  localparam int CW = (clk_per_bit_p > 1) ? $clog2(clk_per_bit_p) : 1;
  localparam logic [CW-1:0] BIT_LAST_C  = CW'(clk_per_bit_p - 1);
  localparam logic [CW-1:0] HALF_LAST_C = CW'(clk_per_bit_p / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE_C   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO_C  = {CW{1'b0}};

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  logic          rx_sync1_r, rx_sync2_r, rx_high_r;
  logic [1:0]    rx_fill_r;
  rx_state_t     rx_state_r;
  logic [CW-1:0] rx_cnt_r;
  logic [2:0]    rx_bit_r;
  logic [7:0]    rx_shift_r, rx_byte_r;
  logic          rx_valid_r;
  logic [7:0]    hold_data_r;
  logic          hold_full_r;
  tx_state_t     tx_state_r;
  logic [CW-1:0] tx_cnt_r;
  logic [2:0]    tx_bit_r;
  logic [7:0]    tx_shift_r;
  logic          tx_r;
  logic          tx_take_s;

  assign tx_take_s = (tx_state_r == TX_IDLE) && hold_full_r;
  assign tx_o      = tx_r;

  // Synchronizer; rx_high_r only trusts the chain once real line data has filled it.
  always_ff @(posedge sys_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_sync1_r <= 1'b1;
      rx_sync2_r <= 1'b1;
      rx_fill_r  <= 2'b00;
      rx_high_r  <= 1'b0;
    end else begin
      rx_sync1_r <= rx_i;
      rx_sync2_r <= rx_sync1_r;
      rx_fill_r  <= {rx_fill_r[0], 1'b1};
      rx_high_r  <= rx_fill_r[1] & rx_sync2_r;
    end
  end

  // Receiver FSM: mid-bit sampling referenced to the start-bit midpoint.
  always_ff @(posedge sys_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= CNT_ZERO_C;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
      rx_byte_r  <= 8'h00;
      rx_valid_r <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          rx_cnt_r <= CNT_ZERO_C;
          rx_bit_r <= 3'd0;
          if (rx_high_r && !rx_sync2_r) begin
            rx_state_r <= RX_START;
          end else begin
            rx_state_r <= RX_IDLE;
          end
        end
        RX_START: begin
          if (rx_cnt_r == HALF_LAST_C) begin
            rx_cnt_r   <= CNT_ZERO_C;
            rx_state_r <= rx_sync2_r ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_ONE_C;
          end
        end
        RX_DATA: begin
          if (rx_cnt_r == BIT_LAST_C) begin
            rx_cnt_r   <= CNT_ZERO_C;
            rx_shift_r <= {rx_sync2_r, rx_shift_r[7:1]};
            if (rx_bit_r == 3'd7) begin
              rx_state_r <= RX_STOP;
            end else begin
              rx_bit_r <= rx_bit_r + 3'd1;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_ONE_C;
          end
        end
        RX_STOP: begin
          if (rx_cnt_r == BIT_LAST_C) begin
            rx_cnt_r   <= CNT_ZERO_C;
            rx_state_r <= RX_IDLE;
            if (rx_sync2_r) begin
              rx_byte_r  <= rx_shift_r;
              rx_valid_r <= 1'b1;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_ONE_C;
          end
        end
        default: begin
          rx_state_r <= RX_IDLE;
          rx_cnt_r   <= CNT_ZERO_C;
        end
      endcase
    end
  end

  // Holding register: a new byte takes priority over the transmitter emptying it.
  always_ff @(posedge sys_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hold_data_r <= 8'h00;
      hold_full_r <= 1'b0;
    end else if (rx_valid_r) begin
      hold_data_r <= rx_byte_r;
      hold_full_r <= 1'b1;
    end else if (tx_take_s) begin
      hold_full_r <= 1'b0;
    end
  end

  // Transmitter FSM; tx_r is the registered line driver.
  always_ff @(posedge sys_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= CNT_ZERO_C;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      tx_r       <= 1'b1;
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          tx_cnt_r <= CNT_ZERO_C;
          tx_bit_r <= 3'd0;
          if (tx_take_s) begin
            tx_state_r <= TX_START;
            tx_shift_r <= hold_data_r;
            tx_r       <= 1'b0;
          end else begin
            tx_state_r <= TX_IDLE;
            tx_r       <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_cnt_r == BIT_LAST_C) begin
            tx_cnt_r   <= CNT_ZERO_C;
            tx_r       <= tx_shift_r[0];
            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
            tx_state_r <= TX_DATA;
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_ONE_C;
          end
        end
        TX_DATA: begin
          if (tx_cnt_r == BIT_LAST_C) begin
            tx_cnt_r <= CNT_ZERO_C;
            if (tx_bit_r == 3'd7) begin
              tx_state_r <= TX_STOP;
              tx_r       <= 1'b1;
            end else begin
              tx_bit_r   <= tx_bit_r + 3'd1;
              tx_r       <= tx_shift_r[0];
              tx_shift_r <= {1'b0, tx_shift_r[7:1]};
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_ONE_C;
          end
        end
        TX_STOP: begin
          if (tx_cnt_r == BIT_LAST_C) begin
            tx_cnt_r   <= CNT_ZERO_C;
            tx_state_r <= TX_IDLE;
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_ONE_C;
          end
          tx_r <= 1'b1;
        end
        default: begin
          tx_state_r <= TX_IDLE;
          tx_cnt_r   <= CNT_ZERO_C;
          tx_r       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_system.sv
// Directed bench for uart_echo_system: drives 8N1 frames on rx and decodes the echo on tx.
module tb_uart_echo_system;

  localparam int P = 16;
  localparam int H = P / 2;

  logic clk;
  logic rst_n;
  logic rx;
  logic tx;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  uart_echo_system #(.clk_per_bit_p(P)) dut (
    .sys_clk_i (clk),
    .reset_n_i (rst_n),
    .rx_i      (rx),
    .tx_o      (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Must be called right after a negedge; t0 is the first posedge that sees the start bit.
  task automatic send_byte(input logic [7:0] d, input logic stop, output int t0);
    rx = 1'b0;
    t0 = cyc + 1;
    repeat (P) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (P) @(negedge clk);
    end
    rx = stop;
    repeat (P) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic quiet(input int n, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic capture(input int budget, output bit found, output int fall,
                         output logic [7:0] data, output bit shape_ok);
    logic vals [0:10*P-1];
    logic mid;
    found = 1'b0;
    fall = 0;
    data = 8'h00;
    shape_ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) return;
    fall = cyc;
    vals[0] = tx;
    for (int i = 1; i < 10*P; i++) begin
      @(posedge clk);
      #1;
      vals[i] = tx;
    end
    shape_ok = 1'b1;
    for (int b = 0; b < 10; b++) begin
      mid = vals[b*P+H];
      if (vals[b*P] !== mid || vals[b*P+P-1] !== mid) shape_ok = 1'b0;
      if (b >= 1 && b <= 8) data[b-1] = mid;
    end
    if (vals[H] !== 1'b0 || vals[9*P+H] !== 1'b1) shape_ok = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (20) @(negedge clk);
    tests++;
    if (tx !== 1'b1) begin
      fails++;
      $display("FAIL reset_tx: tx_o=%b expected 1", tx);
    end
    rst_n = 1'b1;
    quiet(12*P, ok);
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL idle_quiet: tx_o left idle=%b expected 1", ~ok);
    end
  endtask

  task automatic test_echo(input logic [7:0] d, input string name);
    int t0, fall, lat;
    bit found, shape_ok;
    logic [7:0] got;
    @(negedge clk);
    fork
      send_byte(d, 1'b1, t0);
      capture(12*P, found, fall, got, shape_ok);
    join
    tests++;
    if (found !== 1'b1) begin
      fails++;
      $display("FAIL %s_found: echo seen=%b expected 1", name, found);
    end
    lat = fall - (t0 + 9*P + H);
    tests++;
    if (lat < 1 || lat > 4) begin
      fails++;
      $display("FAIL %s_latency: %0d cycles after stop midpoint expected 1..4", name, lat);
    end
    tests++;
    if (shape_ok !== 1'b1) begin
      fails++;
      $display("FAIL %s_shape: bit widths ok=%b expected 1", name, shape_ok);
    end
    tests++;
    if (got !== d) begin
      fails++;
      $display("FAIL %s_data: got 0x%02h expected 0x%02h", name, got, d);
    end
    repeat (2*P) @(negedge clk);
  endtask

  task automatic test_glitch();
    bit ok;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    quiet(12*P, ok);
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL glitch_quiet: echo produced=%b expected 0", ~ok);
    end
    test_echo(8'h3C, "after_glitch");
  endtask

  task automatic test_framing_error();
    int t0;
    bit ok;
    @(negedge clk);
    fork
      send_byte(8'h55, 1'b0, t0);
      quiet(12*P, ok);
    join
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL framing_quiet: echo produced=%b expected 0 (start cycle %0d)", ~ok, t0);
    end
    repeat (2*P) @(negedge clk);
    test_echo(8'h0F, "after_framing");
  endtask

  task automatic test_back_to_back();
    int ta, tb, fa, fb;
    bit f1, f2, s1, s2;
    logic [7:0] d1, d2;
    @(negedge clk);
    fork
      begin
        send_byte(8'h00, 1'b1, ta);
        send_byte(8'hFF, 1'b1, tb);
      end
      begin
        capture(12*P, f1, fa, d1, s1);
        capture(12*P, f2, fb, d2, s2);
      end
    join
    tests++;
    if (f1 !== 1'b1 || s1 !== 1'b1 || d1 !== 8'h00) begin
      fails++;
      $display("FAIL b2b_first: found=%b shape=%b data=0x%02h expected 1 1 0x00", f1, s1, d1);
    end
    tests++;
    if (f2 !== 1'b1 || s2 !== 1'b1 || d2 !== 8'hFF) begin
      fails++;
      $display("FAIL b2b_second: found=%b shape=%b data=0x%02h expected 1 1 0xff", f2, s2, d2);
    end
    tests++;
    if (fb - fa != 10*P + 1) begin
      fails++;
      $display("FAIL b2b_gap: start spacing %0d expected %0d", fb - fa, 10*P + 1);
    end
    tests++;
    if (fa - (ta + 9*P + H) > 4 || fb <= tb + 9*P + H) begin
      fails++;
      $display("FAIL b2b_timing: first lat %0d second lat %0d expected <=4 and >0",
               fa - (ta + 9*P + H), fb - (tb + 9*P + H));
    end
    repeat (2*P) @(negedge clk);
  endtask

  task automatic test_reset_during_tx();
    int t0, fall;
    bit found, ok;
    logic pre, post;
    found = 1'b0;
    fall = 0;
    pre = 1'bx;
    post = 1'bx;
    @(negedge clk);
    fork
      send_byte(8'hA3, 1'b1, t0);
      begin
        for (int i = 0; i < 12*P; i++) begin
          @(posedge clk);
          #1;
          if (tx === 1'b0) begin
            found = 1'b1;
            break;
          end
        end
        if (found) begin
          fall = cyc;
          repeat (4*P + H) @(posedge clk);
          #1;
          pre = tx;
          rst_n = 1'b0;
          #1;
          post = tx;
        end
      end
    join
    tests++;
    if (found !== 1'b1 || fall - (t0 + 9*P + H) > 4) begin
      fails++;
      $display("FAIL rst_tx_start: found=%b lat=%0d expected 1 and <=4", found, fall - (t0 + 9*P + H));
    end
    tests++;
    if (pre !== 1'b0) begin
      fails++;
      $display("FAIL rst_tx_bit3: tx_o=%b expected 0", pre);
    end
    tests++;
    if (post !== 1'b1) begin
      fails++;
      $display("FAIL rst_tx_async: tx_o=%b expected 1", post);
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    quiet(15*P, ok);
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL rst_tx_residual: residual tx=%b expected 0", ~ok);
    end
  endtask

  task automatic test_reset_line_low();
    bit ok;
    @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5*P) @(negedge clk);
    rx = 1'b1;
    quiet(12*P, ok);
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL line_low_release: decoded partial frame=%b expected 0", ~ok);
    end
    test_echo(8'h96, "after_line_low");
  endtask

  initial begin
    test_reset();
    test_echo(8'hA3, "echo_a3");
    test_glitch();
    test_framing_error();
    test_back_to_back();
    test_reset_during_tx();
    test_reset_line_low();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
